// File: rtl/dircc_timer_sequencer_if.sv
// Signal bundle between the timer sequencer, its node-control client and the interval timer.
// master = sequencer view; slave = the surrounding logic (client plus timer slave).
interface dircc_timer_sequencer_if #(
    parameter int COUNT_W = 32
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [31:0]        cfg_period;
    logic               cfg_continuous;
    logic               cfg_stop;
    logic               snap_req;
    logic               snap_valid;
    logic [31:0]        snap_value;
    logic               tick;
    logic [COUNT_W-1:0] tick_count;
    logic               running;
    logic [2:0]         tmr_address;
    logic               tmr_chipselect;
    logic               tmr_write_n;
    logic [15:0]        tmr_writedata;
    logic [15:0]        tmr_readdata;
    logic               tmr_irq;
    logic [3:0]         state_dbg;

    modport master (
        input  cfg_valid, cfg_period, cfg_continuous, cfg_stop, snap_req,
        input  tmr_readdata, tmr_irq,
        output cfg_ready, snap_valid, snap_value, tick, tick_count, running,
        output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata, state_dbg
    );

    modport slave (
        output cfg_valid, cfg_period, cfg_continuous, cfg_stop, snap_req,
        output tmr_readdata, tmr_irq,
        input  cfg_ready, snap_valid, snap_value, tick, tick_count, running,
        input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata, state_dbg
    );
endinterface

// File: rtl/dircc_timer_sequencer.sv
// Avalon-MM master that programs an interval timer, acknowledges its timeouts as ticks
// and reads 32-bit counter snapshots on request.
module dircc_timer_sequencer #(
    parameter int COUNT_W        = 32,
    parameter int DEFAULT_PERIOD = 49999,
    parameter int AUTO_START     = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    dircc_timer_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, STOP, WPL, WPH, WSTAT, WCTRL, RUN, ACK, GUARD, SNAPW, SNAPL, SNAPH
    } state_t;

    state_t             state_q, state_d;
    logic               first_q;
    logic [31:0]        per_q, per_d;
    logic               cont_q, cont_d, stop_q, stop_d;
    logic               snap_pend_q, snap_pend_d, snap_ret_q, snap_ret_d;
    logic               snap_hi_q, snap_hi_d;
    logic [15:0]        snap_lo_q, snap_lo_d;
    logic               snap_valid_q, snap_valid_d;
    logic [31:0]        snap_value_q, snap_value_d;
    logic               tick_q, tick_d, running_q, running_d;
    logic [COUNT_W-1:0] tick_count_q, tick_count_d;
    logic [2:0]         addr_q, addr_d;
    logic               cs_q, cs_d, wn_q, wn_d;
    logic [15:0]        wd_q, wd_d;
    logic               cfg_accept, snap_take;

    // cfg handshake: a request transfers in the cycle cfg_valid && cfg_ready; cfg_ready is
    // only offered in IDLE (not the auto-start cycle) or in RUN with no timeout waiting.
    assign cfg_accept = bus.cfg_valid &&
                        (((state_q == IDLE) && !first_q) || ((state_q == RUN) && !bus.tmr_irq));
    assign snap_take  = bus.snap_req || snap_pend_q;

    assign bus.cfg_ready      = cfg_accept;
    assign bus.snap_valid     = snap_valid_q;
    assign bus.snap_value     = snap_value_q;
    assign bus.tick           = tick_q;
    assign bus.tick_count     = tick_count_q;
    assign bus.running        = running_q;
    assign bus.tmr_address    = addr_q;
    assign bus.tmr_chipselect = cs_q;
    assign bus.tmr_write_n    = wn_q;
    assign bus.tmr_writedata  = wd_q;
    assign bus.state_dbg      = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            first_q      <= 1'b1;
            per_q        <= '0;
            cont_q       <= 1'b0;
            stop_q       <= 1'b0;
            snap_pend_q  <= 1'b0;
            snap_ret_q   <= 1'b0;
            snap_hi_q    <= 1'b0;
            snap_lo_q    <= '0;
            snap_valid_q <= 1'b0;
            snap_value_q <= '0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            running_q    <= 1'b0;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            first_q      <= 1'b0;
            per_q        <= per_d;
            cont_q       <= cont_d;
            stop_q       <= stop_d;
            snap_pend_q  <= snap_pend_d;
            snap_ret_q   <= snap_ret_d;
            snap_hi_q    <= snap_hi_d;
            snap_lo_q    <= snap_lo_d;
            snap_valid_q <= snap_valid_d;
            snap_value_q <= snap_value_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            running_q    <= running_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            wd_q         <= wd_d;
        end
    end

    // Bus fields computed here appear on the timer bus during the state being entered.
    always_comb begin
        state_d      = state_q;
        per_d        = per_q;
        cont_d       = cont_q;
        stop_d       = stop_q;
        snap_pend_d  = snap_pend_q || bus.snap_req;
        snap_ret_d   = snap_ret_q;
        snap_hi_d    = 1'b0;
        snap_lo_d    = snap_lo_q;
        snap_valid_d = 1'b0;
        snap_value_d = snap_value_q;
        tick_d       = 1'b0;
        tick_count_d = tick_count_q;
        running_d    = running_q;
        addr_d       = '0;
        cs_d         = 1'b0;
        wn_d         = 1'b1;
        wd_d         = '0;

        // High snapshot half arrives the cycle after SNAPH, whatever state follows.
        if (snap_hi_q) begin
            snap_value_d = {bus.tmr_readdata, snap_lo_q};
            snap_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (first_q && (AUTO_START != 0)) begin
                    per_d        = 32'(DEFAULT_PERIOD);
                    cont_d       = 1'b1;
                    stop_d       = 1'b0;
                    tick_count_d = '0;
                    {cs_d, wn_d, addr_d, wd_d} = {2'b10, 3'd1, 16'h0008};
                    state_d      = STOP;
                end else if (cfg_accept) begin
                    per_d        = bus.cfg_period;
                    cont_d       = bus.cfg_continuous;
                    stop_d       = bus.cfg_stop;
                    tick_count_d = '0;
                    {cs_d, wn_d, addr_d, wd_d} = {2'b10, 3'd1, 16'h0008};
                    state_d      = STOP;
                end else if (snap_take) begin
                    snap_pend_d  = 1'b0;
                    snap_ret_d   = 1'b0;
                    {cs_d, wn_d, addr_d} = {2'b10, 3'd4};
                    state_d      = SNAPW;
                end
            end
            STOP: begin
                if (stop_q) begin
                    running_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    {cs_d, wn_d, addr_d, wd_d} = {2'b10, 3'd2, per_q[15:0]};
                    state_d   = WPL;
                end
            end
            WPL: begin
                {cs_d, wn_d, addr_d, wd_d} = {2'b10, 3'd3, per_q[31:16]};
                state_d = WPH;
            end
            WPH: begin
                {cs_d, wn_d, addr_d, wd_d} = {2'b10, 3'd0, 16'h0000};
                state_d = WSTAT;
            end
            WSTAT: begin
                {cs_d, wn_d, addr_d, wd_d} = {2'b10, 3'd1, 12'h000, 1'b0, 1'b1, cont_q, 1'b1};
                state_d = WCTRL;
            end
            WCTRL: begin
                running_d = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                if (bus.tmr_irq) begin
                    tick_d       = 1'b1;
                    tick_count_d = tick_count_q + 1'b1;
                    {cs_d, wn_d, addr_d, wd_d} = {2'b10, 3'd0, 16'h0000};
                    state_d      = ACK;
                end else if (cfg_accept) begin
                    per_d        = bus.cfg_period;
                    cont_d       = bus.cfg_continuous;
                    stop_d       = bus.cfg_stop;
                    tick_count_d = '0;
                    {cs_d, wn_d, addr_d, wd_d} = {2'b10, 3'd1, 16'h0008};
                    state_d      = STOP;
                end else if (snap_take) begin
                    snap_pend_d  = 1'b0;
                    snap_ret_d   = 1'b1;
                    {cs_d, wn_d, addr_d} = {2'b10, 3'd4};
                    state_d      = SNAPW;
                end
            end
            ACK: state_d = GUARD;
            // The timer's irq lags the status clear by one cycle, so it is ignored here.
            GUARD: begin
                if (cont_q) begin
                    state_d = RUN;
                end else begin
                    running_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            SNAPW: begin
                addr_d  = 3'd4;
                state_d = SNAPL;
            end
            SNAPL: begin
                addr_d  = 3'd5;
                state_d = SNAPH;
            end
            SNAPH: begin
                snap_lo_d = bus.tmr_readdata;
                snap_hi_d = 1'b1;
                state_d   = snap_ret_q ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dircc_timer_sequencer.sv
// Bench for dircc_timer_sequencer: behavioural interval-timer model, write/tick/snapshot
// monitors, a config vector table and hand-written multi-cycle sequences.
module tb_dircc_timer_sequencer;
  localparam int CW = 3;
  localparam logic [3:0] S_IDLE = 4'd0, S_STOP = 4'd1, S_RUN = 4'd6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  dircc_timer_sequencer_if #(.COUNT_W(CW)) bus ();

  dircc_timer_sequencer #(.COUNT_W(CW), .DEFAULT_PERIOD(49999), .AUTO_START(1)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // clock / reset block
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- timer model ----------------
  logic [31:0] m_period = '0, m_cnt = '0, m_snap = '0, m_load_val = '0;
  logic        m_run = 1'b0, m_cont = 1'b0, m_ito = 1'b0, m_to = 1'b0, m_irq = 1'b0;
  logic [15:0] m_ctrl = '0, m_rd = '0;
  logic        m_load = 1'b0, irq_force = 1'b0;
  logic [31:0] exp_q[$];

  assign bus.tmr_readdata = m_rd;
  assign bus.tmr_irq      = m_irq | irq_force;

  always @(posedge clk) begin
    m_irq <= m_to & m_ito;
    case (bus.tmr_address)
      3'd0: m_rd <= {15'd0, m_to};
      3'd1: m_rd <= m_ctrl;
      3'd2: m_rd <= m_period[15:0];
      3'd3: m_rd <= m_period[31:16];
      3'd4: m_rd <= m_snap[15:0];
      3'd5: m_rd <= m_snap[31:16];
      default: m_rd <= 16'h0;
    endcase
    if (m_load) m_cnt <= m_load_val;
    if (bus.tmr_chipselect && !bus.tmr_write_n) begin
      case (bus.tmr_address)
        3'd0: m_to <= 1'b0;
        3'd1: begin
          m_ctrl <= bus.tmr_writedata;
          m_ito  <= bus.tmr_writedata[0];
          m_cont <= bus.tmr_writedata[1];
          if (bus.tmr_writedata[3]) m_run <= 1'b0;
          else if (bus.tmr_writedata[2]) begin
            m_run <= 1'b1;
            m_cnt <= m_period;
          end
        end
        3'd2: m_period[15:0] <= bus.tmr_writedata;
        3'd3: m_period[31:16] <= bus.tmr_writedata;
        3'd4: begin
          m_snap <= m_cnt;
          exp_q.push_back(m_cnt);
        end
        default: ;
      endcase
    end
    if (m_run && !(bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd1)) begin
      if (m_cnt == 0) begin
        m_to  <= 1'b1;
        m_cnt <= m_period;
        if (!m_cont) m_run <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- monitors ----------------
  logic [18:0] wr_log[$];
  logic [31:0] got_q[$];
  int n_clr = 0, n_tick = 0, cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tmr_chipselect && !bus.tmr_write_n) begin
      wr_log.push_back({bus.tmr_address, bus.tmr_writedata});
      if (bus.tmr_address == 3'd0) n_clr <= n_clr + 1;
    end
    if (bus.tick) n_tick <= n_tick + 1;
    if (bus.snap_valid) got_q.push_back(bus.snap_value);
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cfg(input logic [31:0] p, input logic c, input logic s);
    int lat;
    bus.cfg_period = p;
    bus.cfg_continuous = c;
    bus.cfg_stop = s;
    bus.cfg_valid = 1'b1;
    lat = 0;
    #1;
    while (!bus.cfg_ready && lat < 50) begin
      @(posedge clk);
      #2;
      lat++;
    end
    check("cfg_accept_in_time", 32'(lat < 50), 32'd1);
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(output int at);
    int w;
    w = 0;
    while (!bus.tick && w < 40) begin
      step(1);
      w++;
    end
    check("tick_in_time", 32'(w < 40), 32'd1);
    at = cyc;
  endtask

  logic [18:0] exp_w[0:4];

  task automatic check_log(input string name, input int n);
    check({name, "_nwrites"}, 32'(wr_log.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < wr_log.size()) check({name, "_write"}, 32'(wr_log[i]), 32'(exp_w[i]));
  endtask

  function automatic logic [18:0] wr(input logic [2:0] a, input logic [15:0] d);
    return {a, d};
  endfunction

  typedef struct {
    logic [31:0] period;
    logic        cont;
    logic        stop;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    logic [15:0] exp_ctrl;
    logic        exp_run;
  } cfg_vec_t;

  cfg_vec_t vecs[0:4];

  // ---------------- test ----------------
  initial begin
    int t_prev, t_now, base_clr, base_tick, w;

    vecs[0] = '{32'h0001_86A0, 1'b0, 1'b0, 16'h86A0, 16'h0001, 16'h0005, 1'b1};
    vecs[1] = '{32'hDEAD_BEEF, 1'b1, 1'b0, 16'hBEEF, 16'hDEAD, 16'h0007, 1'b1};
    vecs[2] = '{32'h0000_0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{32'h0001_2345, 1'b1, 1'b0, 16'h2345, 16'h0001, 16'h0007, 1'b1};
    vecs[4] = '{32'h0000_0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0};

    bus.cfg_valid = 1'b0;
    bus.cfg_period = '0;
    bus.cfg_continuous = 1'b0;
    bus.cfg_stop = 1'b0;
    bus.snap_req = 1'b0;

    // reset values
    step(3);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    check("rst_snap_valid", 32'(bus.snap_valid), 32'd0);
    check("rst_snap_value", bus.snap_value, 32'd0);
    check("rst_tick", 32'(bus.tick), 32'd0);
    check("rst_tick_count", 32'(bus.tick_count), 32'd0);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_bus", {bus.tmr_chipselect, bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata},
          {11'd0, 2'b01, 3'd0, 16'd0});
    check("rst_state", 32'(bus.state_dbg), 32'(S_IDLE));

    // auto-start programming sequence
    reset_n = 1'b1;
    wr_log.delete();
    step(5);
    check("auto_running_c5", 32'(bus.running), 32'd0);
    step(1);
    check("auto_running_c6", 32'(bus.running), 32'd1);
    check("auto_state", 32'(bus.state_dbg), 32'(S_RUN));
    exp_w[0] = wr(3'd1, 16'h0008);
    exp_w[1] = wr(3'd2, 16'hC34F);
    exp_w[2] = wr(3'd3, 16'h0000);
    exp_w[3] = wr(3'd0, 16'h0000);
    exp_w[4] = wr(3'd1, 16'h0007);
    check_log("auto", 5);

    // config vector table
    for (int v = 0; v < 5; v++) begin
      wr_log.delete();
      send_cfg(vecs[v].period, vecs[v].cont, vecs[v].stop);
      step(8);
      exp_w[0] = wr(3'd1, 16'h0008);
      exp_w[1] = wr(3'd2, vecs[v].exp_lo);
      exp_w[2] = wr(3'd3, vecs[v].exp_hi);
      exp_w[3] = wr(3'd0, 16'h0000);
      exp_w[4] = wr(3'd1, vecs[v].exp_ctrl);
      check_log("vec", vecs[v].stop ? 1 : 5);
      check("vec_running", 32'(bus.running), 32'(vecs[v].exp_run));
      check("vec_state", 32'(bus.state_dbg), vecs[v].exp_run ? 32'(S_RUN) : 32'(S_IDLE));
      check("vec_tick_count", 32'(bus.tick_count), 32'd0);
    end

    // continuous period 9: ticks every 10 clocks, wrap at 8, one clear per IRQ,
    // snapshot requested during ACK is held and serviced afterwards
    send_cfg(32'd9, 1'b1, 1'b0);
    step(6);
    base_clr = n_clr;
    exp_q.delete();
    got_q.delete();
    t_prev = 0;
    for (int k = 0; k < 9; k++) begin
      wait_tick(t_now);
      if (k > 0) check("tick_interval", 32'(t_now - t_prev), 32'd10);
      t_prev = t_now;
      if (k == 2) check("tick_count_3", 32'(bus.tick_count), 32'd3);
      if (k == 7) check("tick_count_wrap", 32'(bus.tick_count), 32'd0);
      if (k == 8) check("tick_count_after_wrap", 32'(bus.tick_count), 32'd1);
      if (k == 3) bus.snap_req = 1'b1;
      step(1);
      bus.snap_req = 1'b0;
    end
    step(4);
    check("clears_per_irq", 32'(n_clr - base_clr), 32'd9);
    check("run_snap_count", 32'(got_q.size()), 32'd1);
    check("run_snap_exp_count", 32'(exp_q.size()), 32'd1);
    if (got_q.size() > 0 && exp_q.size() > 0)
      check("run_snap_value", got_q[0], exp_q[0]);

    // IRQ and cfg_valid in the same RUN cycle: ACK wins, accept follows GUARD
    send_cfg(32'd9, 1'b1, 1'b0);
    w = 0;
    while (!bus.tmr_irq && w < 40) begin
      step(1);
      w++;
    end
    check("irq_seen", 32'(w < 40), 32'd1);
    check("pre_irq_tick_count", 32'(bus.tick_count), 32'd0);
    bus.cfg_period = 32'h0000_0013;
    bus.cfg_continuous = 1'b1;
    bus.cfg_stop = 1'b0;
    bus.cfg_valid = 1'b1;
    #1;
    check("ready_blocked_by_irq", 32'(bus.cfg_ready), 32'd0);
    step(1);
    check("ack_tick", 32'(bus.tick), 32'd1);
    check("ack_tick_count", 32'(bus.tick_count), 32'd1);
    check("ready_in_ack", 32'(bus.cfg_ready), 32'd0);
    step(1);
    check("ready_in_guard", 32'(bus.cfg_ready), 32'd0);
    step(1);
    check("ready_after_guard", 32'(bus.cfg_ready), 32'd1);
    wr_log.delete();
    step(1);
    bus.cfg_valid = 1'b0;
    check("accept_clears_count", 32'(bus.tick_count), 32'd0);
    check("accept_state", 32'(bus.state_dbg), 32'(S_STOP));
    step(6);
    exp_w[0] = wr(3'd1, 16'h0008);
    exp_w[1] = wr(3'd2, 16'h0013);
    exp_w[2] = wr(3'd3, 16'h0000);
    exp_w[3] = wr(3'd0, 16'h0000);
    exp_w[4] = wr(3'd1, 16'h0007);
    check_log("reprog", 5);

    // stop while running: single stop write, irq never acked afterwards
    wait_tick(t_now);
    step(3);
    wr_log.delete();
    send_cfg(32'd0, 1'b0, 1'b1);
    step(5);
    exp_w[0] = wr(3'd1, 16'h0008);
    check_log("stop", 1);
    check("stop_running", 32'(bus.running), 32'd0);
    check("stop_state", 32'(bus.state_dbg), 32'(S_IDLE));
    base_tick = n_tick;
    irq_force = 1'b1;
    step(20);
    irq_force = 1'b0;
    step(2);
    check("stop_no_ack_writes", 32'(wr_log.size()), 32'd1);
    check("stop_no_ticks", 32'(n_tick - base_tick), 32'd0);

    // one-shot period 4: one tick then idle, bus quiet
    base_tick = n_tick;
    send_cfg(32'd4, 1'b0, 1'b0);
    wait_tick(t_now);
    step(3);
    check("oneshot_running", 32'(bus.running), 32'd0);
    check("oneshot_state", 32'(bus.state_dbg), 32'(S_IDLE));
    check("oneshot_count", 32'(bus.tick_count), 32'd1);
    wr_log.delete();
    step(30);
    check("oneshot_quiet", 32'(wr_log.size()), 32'd0);
    check("oneshot_ticks", 32'(n_tick - base_tick), 32'd1);

    // snapshot while idle with counter 0x0001_2345
    m_load_val = 32'h0001_2345;
    m_load = 1'b1;
    step(1);
    m_load = 1'b0;
    wr_log.delete();
    got_q.delete();
    bus.snap_req = 1'b1;
    step(1);
    bus.snap_req = 1'b0;
    w = 0;
    while (!bus.snap_valid && w < 10) begin
      step(1);
      w++;
    end
    check("idle_snap_seen", 32'(w < 10), 32'd1);
    check("idle_snap_value", bus.snap_value, 32'h0001_2345);
    step(1);
    check("idle_snap_pulse", 32'(bus.snap_valid), 32'd0);
    check("idle_snap_state", 32'(bus.state_dbg), 32'(S_IDLE));
    check("idle_snap_writes", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() > 0) check("idle_snap_addr", 32'(wr_log[0][18:16]), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
